vm_txn_engine: RTL and testbench
================================

// Module: vm_txn_engine
// PURPOSE
//  Transaction engine directly upstream of the vending-machine total register.
//  - Turns coin inserts, item selects and return requests into current_total_nxt.
//  - The total register feeds current_total back to this block.
//  - Owns the inactivity timer and the coin-by-coin change-return sequencer.
// PARAMETERS
//  kNumCoins   3           coin types; values in package: 100, 500, 1000 (ascending)
//  kNumItems   4           item types; prices in package: 400, 500, 1000, 2000
//  kTotalBits  31          width of the total datapath
//  kMaxTotal   100000      largest total accepted; coins exceeding it are rejected
//  kWaitTime   10          idle cycles before change is returned automatically
// PORTS
//  clk                single clock, rising edge
//  reset_n            in   1          asynchronous, active-low reset
//  i_input_coin       in   kNumCoins  bit c = one coin of type c this cycle (several bits allowed)
//  i_select_item      in   kNumItems  bit i = request item i
//  i_trigger_return   in   1          user requests change
//  current_total      in   kTotalBits registered total fed back from the total register
//  current_total_nxt  out  kTotalBits next total; combinational
//  o_available_item   out  kNumItems  bit i = (current_total >= price[i]); all 0 in RETURN; combinational
//  o_output_item      out  kNumItems  registered one-hot pulse, one cycle, on dispense
//  o_return_coin      out  kNumCoins  registered; change coin (one-hot) or rejected coins
//  o_busy             out  1          registered; 1 while in RETURN
// BEHAVIOUR
//  Reset
//  - State IDLE, timer 0, all registered outputs 0.
//  - Total register shares reset_n. Reset mid-return abandons the return (no coins owed).
//  States (FSM)
//  - IDLE: entered with total == 0.
//  - ACTIVE: entered when total_nxt > 0.
//  - RETURN: change-return sequencer running.
//  Transitions
//  - IDLE->ACTIVE when current_total_nxt != 0.
//  - ACTIVE->RETURN when i_trigger_return or the timer expires (timer == 0).
//  - RETURN->IDLE when current_total_nxt == 0.
//  Cycle N in IDLE/ACTIVE
//  - sum = sum of inserted coin values.
//  - If current_total + sum > kMaxTotal: no coins accepted; o_return_coin = i_input_coin in cycle N+1.
//  - Select: only the lowest-index set bit of i_select_item is considered.
//  - Dispense when (current_total + accepted sum) >= price. Then:
//      total_nxt = total + sum - price; o_output_item one-hot in cycle N+1.
//  - Otherwise total_nxt = total + sum.
//  - Timer reloads to kWaitTime on any accepted coin or dispense.
//  - Otherwise the timer decrements by 1 each ACTIVE cycle, saturating at 0.
//  - i_trigger_return in the same cycle as coins/select:
//      coins and select are processed first; RETURN is entered at the next edge.
//  RETURN, each cycle
//  - Pick the largest coin with value <= current_total.
//  - total_nxt = total - value; o_return_coin one-hot in cycle N+1.
//  - Inputs ignored: i_input_coin bits are echoed back on o_return_coin next cycle,
//    OR-ed with the change coin. Select and trigger are dropped.
//  - Residue below the smallest coin (illegal with package values):
//      total_nxt = 0, go to IDLE; the bench asserts this never happens.
//  Width and latency
//  - All arithmetic is done at kTotalBits+1 bits, so the compare never wraps.
//  - Total update latency 1 cycle. Item/coin pulses coincide with the updated current_total.
// STRUCTURE
//  - Package vending_machine_def: kNumCoins, kNumItems, kTotalBits, kMaxTotal, kWaitTime,
//    coin_value[] and item_price[] arrays, state_e enum {IDLE, ACTIVE, RETURN}.
//  - One sub-module vm_wait_timer: load / decrement / expire counter, width $clog2(kWaitTime+1).
//  - FSM, add/subtract datapath and output registers live in vm_txn_engine.
// TESTING
//  T1 insert 500 then 1000 (total 0)
//     -> totals 500, 1500; o_available_item = 4'b0111 after the second coin.
//  T2 total 1500, select item 2 (1000)
//     -> o_output_item = 4'b0100 next cycle; total 500; timer reloaded to 10.
//  T3 total 500, no activity for 10 cycles
//     -> RETURN; o_return_coin = 3'b010 one cycle; total 0; IDLE; o_busy high exactly 1 cycle.
//  T4 total 700, i_trigger_return
//     -> coins returned 500, 100, 100 on consecutive cycles; total 0.
//  T5 total 99500, insert 1000
//     -> rejected; o_return_coin = 3'b100 next cycle; total stays 99500.
//  T6 reset_n low asynchronously during T4 after the first coin
//     -> outputs 0 immediately; IDLE; total 0; no further coins returned.

Source files
------------

// File: rtl/vm_txn_engine_pkg.sv
// Shared definitions for the vending-machine transaction engine: sizes,
// coin values, item prices and the engine state encoding.
// Contents: kNum*/kTotalBits/kMaxTotal/kWaitTime, coin_value[], item_price[], state_e.
package vending_machine_def;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;
  localparam int kMaxTotal  = 100000;
  localparam int kWaitTime  = 10;
  localparam int kTimerBits = $clog2(kWaitTime + 1);

  // One extra bit over the total so sums and compares never wrap.
  typedef logic [kTotalBits:0] ext_total_t;

  // Coin values must stay ascending: the change picker scans from the top.
  localparam ext_total_t coin_value [kNumCoins] = '{100, 500, 1000};
  localparam ext_total_t item_price [kNumItems] = '{400, 500, 1000, 2000};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RETURN = 2'd2
  } state_e;

endpackage

// File: rtl/vm_wait_timer.sv
// Inactivity timer: reloads to kWaitTime on i_load, otherwise counts down on
// i_dec and saturates at zero; o_expired is high while the count is zero.
// Ports: clk, rst_n, i_load, i_dec, o_expired.
module vm_wait_timer
  import vending_machine_def::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  logic [kTimerBits-1:0] count_q;
  logic [kTimerBits-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = kTimerBits'(kWaitTime);
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == '0);

endmodule

// File: rtl/vm_txn_engine.sv
// Vending-machine transaction engine: turns coins, selects and return requests
// into the next total, and runs the coin-by-coin change-return sequencer.
// Ports: clk, reset_n, coin/select/return inputs, current_total in,
//        current_total_nxt/o_available_item (comb), o_output_item/o_return_coin/o_busy (registered).
module vm_txn_engine
  import vending_machine_def::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kTotalBits-1:0] current_total_nxt,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy
);

  state_e               state_q, state_d;
  logic [kNumItems-1:0] output_item_q, output_item_d;
  logic [kNumCoins-1:0] return_coin_q, return_coin_d;
  logic                 busy_q, busy_d;

  ext_total_t           total_ext;
  ext_total_t           coin_sum;
  ext_total_t           accepted_sum;
  ext_total_t           avail_ext;
  ext_total_t           sel_price;
  ext_total_t           change_val;
  ext_total_t           nxt_ext;
  logic [kNumItems-1:0] sel_onehot;
  logic [kNumCoins-1:0] change_coin;
  logic                 change_found;
  logic                 dispense;
  logic                 timer_load;
  logic                 timer_dec;
  logic                 timer_expired;
  logic                 nxt_unused_msb;

  vm_wait_timer u_wait_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_load    (timer_load),
    .i_dec     (timer_dec),
    .o_expired (timer_expired)
  );

  assign total_ext = {1'b0, current_total};

  // Keep only the lowest-index requested item.
  assign sel_onehot = i_select_item & (~i_select_item + 1'b1);

  always_comb begin
    coin_sum  = '0;
    sel_price = '0;
    for (int c = 0; c < kNumCoins; c++) begin
      if (i_input_coin[c]) coin_sum = coin_sum + coin_value[c];
    end
    for (int i = 0; i < kNumItems; i++) begin
      if (sel_onehot[i]) sel_price = sel_price | item_price[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    output_item_d = '0;
    return_coin_d = '0;
    nxt_ext       = total_ext;
    accepted_sum  = '0;
    avail_ext     = total_ext;
    dispense      = 1'b0;
    timer_load    = 1'b0;
    timer_dec     = 1'b0;
    change_found  = 1'b0;
    change_coin   = '0;
    change_val    = '0;

    case (state_q)
      IDLE, ACTIVE: begin
        // An overflowing insert is rejected as a whole and handed straight back.
        if ((total_ext + coin_sum) > ext_total_t'(kMaxTotal)) begin
          return_coin_d = i_input_coin;
        end else begin
          accepted_sum = coin_sum;
        end
        avail_ext = total_ext + accepted_sum;
        dispense  = (sel_onehot != '0) && (avail_ext >= sel_price);
        if (dispense) begin
          nxt_ext       = avail_ext - sel_price;
          output_item_d = sel_onehot;
        end else begin
          nxt_ext = avail_ext;
        end
        timer_load = (accepted_sum != '0) || dispense;
        timer_dec  = (state_q == ACTIVE) && !timer_load;

        if (nxt_ext == '0) begin
          state_d = IDLE;
        end else if (i_trigger_return) begin
          // A return request in the same cycle as money/select still honours
          // that activity first; the sequencer starts on the next edge.
          state_d = RETURN;
        end else if (state_q == ACTIVE && timer_expired && !timer_load) begin
          state_d = RETURN;
        end else begin
          state_d = ACTIVE;
        end
      end

      RETURN: begin
        // Largest coin not exceeding the remaining total.
        for (int c = kNumCoins - 1; c >= 0; c--) begin
          if (!change_found && (coin_value[c] <= total_ext)) begin
            change_found   = 1'b1;
            change_coin[c] = 1'b1;
            change_val     = coin_value[c];
          end
        end
        // Coins inserted while returning are not accepted; they ride back out.
        return_coin_d = change_coin | i_input_coin;
        nxt_ext       = change_found ? (total_ext - change_val) : '0;
        if (nxt_ext == '0) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RETURN);
  end

  assign current_total_nxt = nxt_ext[kTotalBits-1:0];
  assign nxt_unused_msb    = nxt_ext[kTotalBits];

  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < kNumItems; i++) begin
      o_available_item[i] = (state_q != RETURN) && (total_ext >= item_price[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      output_item_q <= '0;
      return_coin_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      output_item_q <= output_item_d;
      return_coin_q <= return_coin_d;
      busy_q        <= busy_d;
    end
  end

  assign o_output_item = output_item_q;
  assign o_return_coin = return_coin_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_vm_txn_engine.sv
// Directed bench for vm_txn_engine with a local model of the total register.
module tb_vm_txn_engine;
  import vending_machine_def::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic [30:0] current_total;
  logic [30:0] current_total_nxt;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  vm_txn_engine dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_input_coin      (i_input_coin),
    .i_select_item     (i_select_item),
    .i_trigger_return  (i_trigger_return),
    .current_total     (current_total),
    .current_total_nxt (current_total_nxt),
    .o_available_item  (o_available_item),
    .o_output_item     (o_output_item),
    .o_return_coin     (o_return_coin),
    .o_busy            (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External total register, sharing reset_n with the engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) current_total <= '0;
    else          current_total <= current_total_nxt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A sub-coin residue must never be seen while returning.
  always @(negedge clk) begin
    if (reset_n && dut.state_q == RETURN && current_total != 0 && current_total < 31'd100)
      chk("residue_in_return", {1'b0, current_total}, 32'd0);
  end

  initial begin
    bit done;
    reset_n          = 1'b0;
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;
    #2;
    chk("rst_total", {1'b0, current_total}, 0);
    chk("rst_item", {28'd0, o_output_item}, 0);
    chk("rst_coin", {29'd0, o_return_coin}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_avail", {28'd0, o_available_item}, 0);
    #11 reset_n = 1'b1;
    step();

    // T1: 500 then 1000
    i_input_coin = 3'b010; #1;
    chk("t1_nxt500", {1'b0, current_total_nxt}, 500);
    step(); i_input_coin = 3'b000;
    chk("t1_tot500", {1'b0, current_total}, 500);
    i_input_coin = 3'b100;
    step(); i_input_coin = 3'b000;
    chk("t1_tot1500", {1'b0, current_total}, 1500);
    chk("t1_avail", {28'd0, o_available_item}, 32'b0111);

    // T2: select item 2 (1000)
    i_select_item = 4'b0100; #1;
    chk("t2_nxt", {1'b0, current_total_nxt}, 500);
    step(); i_select_item = 4'b0000;
    chk("t2_item", {28'd0, o_output_item}, 32'b0100);
    chk("t2_total", {1'b0, current_total}, 500);
    chk("t2_timer", {28'd0, dut.u_wait_timer.count_q}, 10);
    step();
    chk("t2_item_pulse", {28'd0, o_output_item}, 0);

    // T3: idle timeout (timer now 9; nine more cycles to reach 0)
    repeat (9) step();
    chk("t3_not_yet", {31'd0, o_busy}, 0);
    step();
    chk("t3_busy", {31'd0, o_busy}, 1);
    chk("t3_avail_ret", {28'd0, o_available_item}, 0);
    step();
    chk("t3_coin", {29'd0, o_return_coin}, 32'b010);
    chk("t3_total", {1'b0, current_total}, 0);
    chk("t3_busy_low", {31'd0, o_busy}, 0);
    step();
    chk("t3_coin_pulse", {29'd0, o_return_coin}, 0);

    // T4: 700 returned as 500,100,100; a coin inserted mid-return is echoed
    i_input_coin = 3'b011; step();
    i_input_coin = 3'b001; step();
    i_input_coin = 3'b000;
    chk("t4_total", {1'b0, current_total}, 700);
    i_trigger_return = 1'b1; step(); i_trigger_return = 1'b0;
    chk("t4_busy", {31'd0, o_busy}, 1);
    i_input_coin = 3'b001; step(); i_input_coin = 3'b000;
    chk("t4_c1", {29'd0, o_return_coin}, 32'b011);
    chk("t4_t1", {1'b0, current_total}, 200);
    step();
    chk("t4_c2", {29'd0, o_return_coin}, 32'b001);
    chk("t4_t2", {1'b0, current_total}, 100);
    step();
    chk("t4_c3", {29'd0, o_return_coin}, 32'b001);
    chk("t4_t3", {1'b0, current_total}, 0);
    chk("t4_idle", {31'd0, o_busy}, 0);

    // Select priority and insufficient funds
    i_input_coin = 3'b010; step(); i_input_coin = 3'b000;
    i_select_item = 4'b1000; step();
    chk("sel_short_item", {28'd0, o_output_item}, 0);
    chk("sel_short_total", {1'b0, current_total}, 500);
    i_select_item = 4'b1010; step(); i_select_item = 4'b0000;
    chk("sel_low_item", {28'd0, o_output_item}, 32'b0010);
    chk("sel_low_total", {1'b0, current_total}, 0);

    // T5: build 99500, overflow reject, then exact-max accept
    repeat (99) begin i_input_coin = 3'b100; step(); end
    i_input_coin = 3'b010; step();
    chk("t5_total", {1'b0, current_total}, 99500);
    i_input_coin = 3'b100; #1;
    chk("t5_nxt", {1'b0, current_total_nxt}, 99500);
    step(); i_input_coin = 3'b000;
    chk("t5_reject", {29'd0, o_return_coin}, 32'b100);
    chk("t5_hold", {1'b0, current_total}, 99500);
    i_input_coin = 3'b010; step(); i_input_coin = 3'b000;
    chk("t5_max_ok", {1'b0, current_total}, 100000);
    chk("t5_max_nocoin", {29'd0, o_return_coin}, 0);
    i_trigger_return = 1'b1; step(); i_trigger_return = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      if (current_total == 0 && !o_busy) done = 1'b1;
    end
    chk("t5_drain_done", {31'd0, done}, 1);
    chk("t5_drain_total", {1'b0, current_total}, 0);

    // T6: async reset after the first change coin
    i_input_coin = 3'b011; step();
    i_input_coin = 3'b001; step();
    i_input_coin = 3'b000;
    i_trigger_return = 1'b1; step(); i_trigger_return = 1'b0;
    step();
    chk("t6_first", {29'd0, o_return_coin}, 32'b010);
    #2 reset_n = 1'b0; #1;
    chk("t6_coin0", {29'd0, o_return_coin}, 0);
    chk("t6_busy0", {31'd0, o_busy}, 0);
    chk("t6_total0", {1'b0, current_total}, 0);
    #3 reset_n = 1'b1;
    step();
    chk("t6_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    step();
    chk("t6_no_more", {29'd0, o_return_coin}, 0);
    chk("t6_total_stay", {1'b0, current_total}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
